// File: rtl/if_stage.sv
// if_stage: PC register and single-outstanding instruction fetch on an SRAM-like bus,
// handing {pc, inst} to decode over valid/ready with redirect and stale-response discard.
module if_stage #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic [31:0]       inst_rdata,
    input  logic              inst_data_ok,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       id_inst,
    output logic [ADDR_W-1:0] id_pc,
    output logic              id_adel,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
);
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_HALT} state_t;
    state_t            r_state;
    logic [ADDR_W-1:0] r_pc, r_id_pc;
    logic [31:0]       r_id_inst;
    logic              r_discard, r_err, r_id_valid, r_id_adel;
    logic              w_misal;
    assign w_misal   = |r_pc[1:0];
    assign inst_req  = rstn && r_state == S_REQ && !w_misal;
    assign inst_addr = r_pc;
    assign id_valid  = r_id_valid;
    assign id_inst   = r_id_inst;
    assign id_pc     = r_id_pc;
    assign id_adel   = r_id_adel;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pc       <= RESET_PC;
            r_state    <= S_REQ;
            r_discard  <= 1'b0;
            r_err      <= 1'b0;
            r_id_valid <= 1'b0;
            r_id_inst  <= '0;
            r_id_pc    <= '0;
            r_id_adel  <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (redirect) begin
                        r_pc <= redirect_pc;
                        if (!w_misal && inst_addr_ok) begin
                            r_discard <= 1'b1;
                            r_state   <= S_WAIT;
                        end
                    end else if (w_misal) begin
                        r_id_valid <= 1'b1;
                        r_id_inst  <= '0;
                        r_id_pc    <= r_pc;
                        r_id_adel  <= 1'b1;
                        r_err      <= 1'b1;
                        r_state    <= S_HOLD;
                    end else if (inst_addr_ok) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        r_pc      <= redirect_pc;
                        r_discard <= !inst_data_ok;
                        if (inst_data_ok) r_state <= S_REQ;
                    end else if (inst_data_ok && r_discard) begin
                        r_discard <= 1'b0;
                        r_state   <= S_REQ;
                    end else if (inst_data_ok) begin
                        r_id_valid <= 1'b1;
                        r_id_inst  <= inst_rdata;
                        r_id_pc    <= r_pc;
                        r_id_adel  <= 1'b0;
                        r_err      <= 1'b0;
                        r_pc       <= r_pc + ADDR_W'(4);
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // redirect flushes the held word; a simultaneous id_ready still counts as taken
                    if (redirect || id_ready) begin
                        r_id_valid <= 1'b0;
                        r_state    <= (!redirect && r_err) ? S_HALT : S_REQ;
                        if (redirect) r_pc <= redirect_pc;
                    end
                end
                S_HALT: begin
                    if (redirect) begin
                        r_pc    <= redirect_pc;
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed tests of if_stage against a word-memory responder and
// rule-based per-cycle checks (delivered inst equals memory at its pc, stable while stalled).
module tb_if_stage;
    logic        clk = 1'b0, rstn = 1'b0;
    logic        inst_req, inst_addr_ok, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        id_valid, id_ready = 1'b1, id_adel;
    logic [31:0] id_inst, id_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    if_stage dut (
        .clk(clk), .rstn(rstn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
        .id_adel(id_adel), .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic [31:0] g_pc[$], g_inst[$], acc[$];
    logic        g_adel[$];

    // memory responder: addr_ok after ok_delay waiting cycles, data_ok lat cycles after acceptance
    int          ok_delay = 0, lat = 1, wc = 0, cnt = 0, resp_cnt = 0;
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'd0;
    initial begin
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'd0;
        forever begin
            @(posedge clk); #2;
            inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
            if (pend) begin
                if (cnt == 0) begin
                    inst_data_ok = 1'b1; inst_rdata = mem(paddr); pend = 1'b0; resp_cnt++;
                end else cnt--;
            end else if (inst_req) begin
                if (wc >= ok_delay) begin
                    inst_addr_ok = 1'b1; pend = 1'b1; paddr = inst_addr; cnt = lat - 1; wc = 0;
                end else wc++;
            end else wc = 0;
        end
    end

    logic        p_stall = 1'b0;
    logic [31:0] p_pc = 32'd0, p_inst = 32'd0;
    always @(negedge clk) begin
        if (!rstn) chk("req_in_reset", 32'(inst_req), 32'd0);
        else begin
            if (p_stall) begin
                chk("hold_valid", 32'(id_valid), 32'd1);
                chk("hold_pc", id_pc, p_pc);
                chk("hold_inst", id_inst, p_inst);
            end
            if (id_valid) begin
                chk("adel_rule", 32'(id_adel), 32'(id_pc[1:0] != 2'd0));
                chk("inst_rule", id_inst, id_adel ? 32'd0 : mem(id_pc));
            end
            if (inst_req) chk("req_aligned", 32'(inst_addr[1:0]), 32'd0);
            if (id_valid && id_ready) begin
                g_pc.push_back(id_pc); g_inst.push_back(id_inst); g_adel.push_back(id_adel);
            end
            if (inst_req && inst_addr_ok) acc.push_back(inst_addr);
        end
        p_stall <= rstn && id_valid && !id_ready && !redirect;
        p_pc    <= id_pc;
        p_inst  <= id_inst;
    end

    task automatic clear_logs();
        g_pc.delete(); g_inst.delete(); g_adel.delete(); acc.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk); #1;
        while (pend) begin @(posedge clk); #1; end
        rstn = 1'b1;
        clear_logs();
        resp_cnt = 0;
    endtask

    task automatic wait_got(input int n);
        int k = 0;
        while (g_pc.size() < n && k < 200) begin @(posedge clk); #1; k++; end
        chk("wait_got", 32'(g_pc.size() >= n), 32'd1);
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        while (acc.size() < n && k < 200) begin @(posedge clk); #1; k++; end
        chk("wait_acc", 32'(acc.size() >= n), 32'd1);
    endtask

    task automatic wait_valid();
        int k = 0;
        while (!id_valid && k < 200) begin @(posedge clk); #1; k++; end
        chk("wait_valid", 32'(id_valid), 32'd1);
    endtask

    task automatic pulse_redirect(input logic [31:0] t);
        redirect = 1'b1; redirect_pc = t;
        @(posedge clk); #1;
        redirect = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset state and free-running fetch
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_inst", id_inst, 32'd0);
        chk("rst_adel", 32'(id_adel), 32'd0);
        chk("rst_req", 32'(inst_req), 32'd0);
        chk("rst_addr", inst_addr, 32'hBFC0_0000);
        @(posedge clk); #1;
        rstn = 1'b1;
        wait_got(3);
        chk("run_acc0", acc[0], 32'hBFC0_0000);
        chk("run_acc1", acc[1], 32'hBFC0_0004);
        chk("run_acc2", acc[2], 32'hBFC0_0008);
        chk("run_pc0", g_pc[0], 32'hBFC0_0000);
        chk("run_inst0", g_inst[0], 32'h1357_DBE0);
        chk("run_pc1", g_pc[1], 32'hBFC0_0004);
        chk("run_inst1", g_inst[1], 32'h1353_DBE0);
        chk("run_adel0", 32'(g_adel[0]), 32'd0);

        // backpressure
        id_ready = 1'b0;
        do_reset();
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            chk("bp_req", 32'(inst_req), 32'd0);
            chk("bp_pc", id_pc, 32'hBFC0_0000);
        end
        @(posedge clk); #1;
        id_ready = 1'b1;
        wait_acc(2);
        chk("bp_next", acc[1], 32'hBFC0_0004);

        // redirect in WAIT one cycle before data_ok
        lat = 3;
        do_reset();
        wait_acc(1);
        @(posedge clk); #1;
        pulse_redirect(32'h8000_1000);
        wait_got(1);
        chk("rw_pc", g_pc[0], 32'h8000_1000);
        chk("rw_acc", acc[1], 32'h8000_1000);

        // redirect in REQ while the memory stalls addr_ok
        lat = 1; ok_delay = 3;
        do_reset();
        @(posedge clk); #1;
        pulse_redirect(32'h8000_2000);
        @(negedge clk);
        chk("rr_req", 32'(inst_req), 32'd1);
        chk("rr_addr", inst_addr, 32'h8000_2000);
        wait_got(1);
        chk("rr_resp_cnt", 32'(resp_cnt), 32'd1);
        chk("rr_acc_n", 32'(acc.size()), 32'd1);
        chk("rr_acc", acc[0], 32'h8000_2000);
        chk("rr_pc", g_pc[0], 32'h8000_2000);

        // misaligned redirect, error hold, HALT, restart
        id_ready = 1'b0;
        do_reset();
        pulse_redirect(32'h8000_0002);
        @(negedge clk);
        chk("ma_req", 32'(inst_req), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ma_valid", 32'(id_valid), 32'd1);
        chk("ma_adel", 32'(id_adel), 32'd1);
        chk("ma_inst", id_inst, 32'd0);
        chk("ma_pc", id_pc, 32'h8000_0002);
        @(posedge clk); #1;
        id_ready = 1'b1;
        @(posedge clk); #1;
        repeat (4) begin
            @(negedge clk);
            chk("halt_req", 32'(inst_req), 32'd0);
            chk("halt_valid", 32'(id_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk("ma_got_adel", 32'(g_adel[0]), 32'd1);
        ok_delay = 0;
        pulse_redirect(32'hBFC0_0380);
        wait_acc(1);
        chk("halt_exit", acc[0], 32'hBFC0_0380);

        // reset during WAIT, stale data_ok afterwards
        lat = 3;
        do_reset();
        wait_acc(1);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_wait_valid", 32'(id_valid), 32'd0);
        end
        wait_got(1);
        chk("rst_wait_pc", g_pc[0], 32'hBFC0_0000);
        chk("rst_wait_acc", acc[1], 32'hBFC0_0000);

        // pc wrap
        lat = 1;
        pulse_redirect(32'hFFFF_FFFC);
        clear_logs();
        wait_got(2);
        chk("wrap_pc0", g_pc[0], 32'hFFFF_FFFC);
        chk("wrap_pc1", g_pc[1], 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the datapath.
- Holds the PC and issues word fetches on an SRAM-like instruction bus (req/addr_ok/data_ok, one outstanding request).
- Presents {pc, instruction} to the datapath decode input through a valid/ready handshake.
- Accepts branch/jump/exception redirects from the datapath and discards stale in-flight responses.

Parameters:
RESET_PC  32'hBFC0_0000  PC loaded on reset
ADDR_W  32  PC/address width; the data width is fixed at 32

Ports:
clk  in  1  single clock, rising edge
rstn  in  1  synchronous active-low reset
inst_req  out  1  fetch request valid
inst_addr  out  ADDR_W  fetch address (the PC)
inst_addr_ok  in  1  request accepted this cycle (inst_req & inst_addr_ok)
inst_rdata  in  32  fetched word, valid with inst_data_ok
inst_data_ok  in  1  response valid, one cycle
id_valid  out  1  instruction available to the datapath
id_ready  in  1  datapath accepts this cycle (id_valid & id_ready)
id_inst  out  32  instruction word
id_pc  out  ADDR_W  PC of id_inst
id_adel  out  1  fetch address error (pc[1:0]!=0); id_inst is 0 when set
redirect  in  1  one-cycle PC redirect from the datapath
redirect_pc  in  ADDR_W  redirect target

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low: on a clk edge with rstn=0, the following are loaded.
  - pc=RESET_PC, state=REQ, discard=0.
  - id_valid=0, id_inst=0, id_pc=0, id_adel=0.
  - inst_req is 0 while rstn=0.
  - inst_addr=pc at all times.
- States: REQ, WAIT, HOLD, HALT.
- REQ, aligned pc:
  - inst_req=1; inst_addr must stay stable until inst_addr_ok.
  - addr_ok -> WAIT.
  - redirect without addr_ok -> pc<=redirect_pc, stay REQ. The unaccepted address may change.
  - redirect with addr_ok -> pc<=redirect_pc, discard<=1, WAIT.
- REQ, misaligned pc (pc[1:0]!=0):
  - inst_req=0; no bus request is issued.
  - Next edge: id_valid<=1, id_inst<=0, id_pc<=pc, id_adel<=1 -> HOLD. An internal flag marks the HOLD as an error hold.
- WAIT:
  - inst_req=0; wait for inst_data_ok.
  - data_ok with discard=1: drop the word, discard<=0 -> REQ.
  - data_ok with discard=0 and no redirect: id_inst<=inst_rdata, id_pc<=pc, id_adel<=0, id_valid<=1, pc<=pc+4 -> HOLD.
  - redirect without data_ok: pc<=redirect_pc, discard<=1, stay WAIT.
  - redirect with data_ok: drop the word, pc<=redirect_pc, discard<=0 -> REQ.
- HOLD (id_valid=1):
  - Outputs stay stable until the handshake.
  - id_ready -> id_valid<=0; go to REQ, or to HALT if this was an error hold.
  - redirect -> id_valid<=0, pc<=redirect_pc -> REQ. The held instruction is flushed unless id_ready=1 in the same cycle, in which case the transfer counts as completed.
- HALT:
  - No requests; id_valid=0; waits for redirect.
  - redirect -> pc<=redirect_pc -> REQ.
- Redirect priority: redirect overrides every other next-PC source in every state.
- Arithmetic: pc+4 is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
- Outstanding requests: at most one in flight.
- Bus protocol edge cases:
  - inst_data_ok outside WAIT is ignored, e.g. a stale response after a reset mid-operation.
  - inst_addr_ok outside REQ with inst_req=1 is ignored.
- Latency and throughput:
  - Request-to-id_valid latency = 1 + memory latency.
  - Best-case throughput is 1 instruction per 3 cycles (REQ, WAIT, HOLD), with addr_ok and data_ok on consecutive cycles.

Test Plan:
- Reset then free-run, with addr_ok immediate and data_ok 1 cycle later, id_ready=1:
  - inst_addr sequence is BFC00000, BFC00004, BFC00008.
  - id_pc/id_inst match the memory contents; id_adel=0.
- Backpressure: id_ready=0 for 5 cycles while id_valid=1:
  - id_inst/id_pc stay stable and inst_req=0 throughout.
  - On id_ready=1 the next fetch is BFC00004.
- Redirect in WAIT: redirect to 80001000 one cycle before data_ok:
  - The stale word never reaches id_valid.
  - Next inst_addr=80001000; id_pc=80001000.
- Redirect in REQ while addr_ok=0 (memory stalls 3 cycles):
  - inst_addr switches to redirect_pc; inst_req stays 1.
  - After acceptance, exactly one response is delivered.
- Misaligned redirect to 80000002:
  - No inst_req.
  - id_valid=1 with id_adel=1, id_inst=0, id_pc=80000002.
  - After the handshake the block sits in HALT until a redirect to BFC00380, then fetches BFC00380.
- Reset during WAIT: rstn=0 one cycle, then data_ok arrives:
  - The response is ignored.
  - id_valid stays 0 and the fetch restarts at BFC00000.
  - Also check PC wrap: redirect to FFFFFFFC, then next fetch address is 00000000.
